// File: rtl/sreg_sched_pkg.sv
// rtl/sreg_sched_pkg.sv - shared types and constants for the shift-register frame scheduler
//
// Contents:
//   WIDTH_DEF  default frame width / chain depth
//   state_t    scheduler FSM states
//   req_id_t   requester identifier (0 or 1)
//   cnt_w()    counter width helper, never returns less than 1 bit
package sreg_sched_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef logic req_id_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sreg_frame_sched_if.sv
// rtl/sreg_frame_sched_if.sv - requester and chain signal bundle for sreg_frame_sched
//
// Signals:
//   req0_valid/req0_data/req0_ready  requester 0 byte handshake
//   req1_valid/req1_data/req1_ready  requester 1 byte handshake
//   sr_clr/sr_shift_en/sr_din        drive into the serial-in chain
//   sr_pout                          chain parallel output
//   done/done_data/done_id/done_err  frame completion report
//   busy                             scheduler not idle
// Modports:
//   master  requester / chain side
//   slave   scheduler side
interface sreg_frame_sched_if #(
  parameter int WIDTH = sreg_sched_pkg::WIDTH_DEF
) ();

  logic                     req0_valid;
  logic [WIDTH-1:0]         req0_data;
  logic                     req0_ready;
  logic                     req1_valid;
  logic [WIDTH-1:0]         req1_data;
  logic                     req1_ready;
  logic                     sr_clr;
  logic                     sr_shift_en;
  logic                     sr_din;
  logic [WIDTH-1:0]         sr_pout;
  logic                     done;
  logic [WIDTH-1:0]         done_data;
  sreg_sched_pkg::req_id_t  done_id;
  logic                     done_err;
  logic                     busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, sr_pout,
    input  req0_ready, req1_ready, sr_clr, sr_shift_en, sr_din,
           done, done_data, done_id, done_err, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, sr_pout,
    output req0_ready, req1_ready, sr_clr, sr_shift_en, sr_din,
           done, done_data, done_id, done_err, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant memory
//
// Ports:
//   clk, res      clock, asynchronous active-low reset
//   en            arbitration allowed this cycle
//   valid0/1      requests
//   upd           a transfer completed this cycle; remember the winner
//   gnt0/1        combinational grants, at most one high
module rr_arb2
  import sreg_sched_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  input  logic upd,
  output logic gnt0,
  output logic gnt1
);

  // Resets to 1 so requester 0 wins the first tie.
  req_id_t last_gnt;

  // A lone request always wins; on a tie the requester not served last wins.
  assign gnt0 = en & valid0 & (~valid1 | last_gnt);
  assign gnt1 = en & valid1 & (~valid0 | ~last_gnt);

  // Only a completed transfer moves the pointer, so a withdrawn request
  // leaves the fairness order untouched.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      last_gnt <= 1'b1;
    end else if (upd) begin
      last_gnt <= gnt1;
    end
  end

endmodule

// File: rtl/sreg_frame_sched.sv
// rtl/sreg_frame_sched.sv - arbitrating serializer for an 8-bit SIPO shift-register chain
//
// Ports:
//   clk  clock, all state on rising edge
//   res  asynchronous active-low reset
//   bus  sreg_frame_sched_if.slave: two requester handshakes, chain drive
//        (sr_clr, sr_shift_en, sr_din), chain readback (sr_pout), frame
//        report (done, done_data, done_id, done_err) and busy
// Parameters:
//   WIDTH    frame width in bits, equal to chain depth
//   GAP_CYC  idle cycles enforced between frames (0 allowed)
module sreg_frame_sched
  import sreg_sched_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             res,
  sreg_frame_sched_if.slave bus
);

  localparam int              CW       = cnt_w(WIDTH);
  localparam int              GW       = cnt_w(GAP_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam int              GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] hold;
  req_id_t          owner;

  logic             done_q;
  logic [WIDTH-1:0] done_data_q;
  req_id_t          done_id_q;
  logic             done_err_q;

  logic             arb_en;
  logic             gnt0;
  logic             gnt1;
  logic             xfer;
  logic             gap_last;

  // Gating with res keeps ready and sr_clr low while reset is held even
  // if a requester is presenting valid.
  assign arb_en   = (state == ST_IDLE) & res;
  assign xfer     = gnt0 | gnt1;
  assign gap_last = (gap_cnt == GW'(GAP_LAST));

  rr_arb2 u_arb (
    .clk    (clk),
    .res    (res),
    .en     (arb_en),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .upd    (xfer),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (xfer) state_n = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_LAST) state_n = ST_CHECK;
      ST_CHECK: state_n = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_last) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gap_cnt     <= '0;
      hold        <= '0;
      owner       <= 1'b0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      done_id_q   <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            // hold is the only source of the frame from here on, so the
            // requester may change or drop its data freely.
            hold  <= gnt1 ? bus.req1_data : bus.req0_data;
            owner <= gnt1;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          // Explicit terminal wrap keeps non-power-of-two widths in range.
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        ST_CHECK: begin
          done_q      <= 1'b1;
          done_data_q <= bus.sr_pout;
          done_id_q   <= owner;
          done_err_q  <= (bus.sr_pout != hold);
          gap_cnt     <= '0;
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.sr_clr      = xfer;

  // Decoded purely from flops: MSB first, one bit per SHIFT cycle.
  assign bus.sr_shift_en = (state == ST_SHIFT);
  assign bus.sr_din      = (state == ST_SHIFT) & hold[CNT_LAST - cnt];

  assign bus.done        = done_q;
  assign bus.done_data   = done_data_q;
  assign bus.done_id     = done_id_q;
  assign bus.done_err    = done_err_q;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: doc/sreg_frame_sched.md
Name: sreg_frame_sched

Overview:
Controller and arbiter for the team's 8-bit serial-in/parallel-out shift register chain.
- Accepts bytes from two requesters via valid/ready and arbitrates round-robin.
- Serializes the granted byte into the chain MSB-first, one bit per clock, gated by a shift enable.
- After the last shift, samples the chain's parallel output, reports it with requester id, and flags a loopback mismatch.

Parameters:
WIDTH, 8, frame width in bits; equals chain depth
GAP_CYC, 1, idle cycles enforced between frames (0 allowed)

Ports:
clk  in  1  clock; all state on rising edge
res  in  1  reset; asynchronous, active-low (res=0 resets)
req0_valid  in  1  requester 0 has a byte
req0_data  in  WIDTH  requester 0 byte
req0_ready  out  1  requester 0 accepted this cycle
req1_valid  in  1  requester 1 has a byte
req1_data  in  WIDTH  requester 1 byte
req1_ready  out  1  requester 1 accepted this cycle
sr_clr  out  1  synchronous clear pulse to chain
sr_shift_en  out  1  chain shifts on this edge
sr_din  out  1  serial bit into chain
sr_pout  in  WIDTH  chain parallel output; first-shifted bit lands at [WIDTH-1]
done  out  1  one-cycle frame-complete pulse
done_data  out  WIDTH  sr_pout captured at completion
done_id  out  1  requester that owned the frame
done_err  out  1  captured byte != accepted byte
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, SHIFT, CHECK, GAP.
- Reset (res=0, async): state=IDLE, cnt=0, hold=0, owner=0, last_gnt=1 (req0 wins first tie).
  - All outputs 0.
  - An in-flight frame is dropped; no done is issued.
- IDLE:
  - Grant arbitration, combinational from state and valids:
    - only one valid -> grant it;
    - both valid -> grant !last_gnt.
  - reqN_ready = (state==IDLE) & gntN. At most one ready is high; ready is never high outside IDLE.
  - Transfer on valid&ready (cycle T):
    - latch hold=data, owner=N, last_gnt=N;
    - sr_clr=1 for that cycle only;
    - next state SHIFT, cnt=0.
- SHIFT, cycles T+1..T+WIDTH:
  - sr_shift_en=1; sr_din=hold[WIDTH-1-cnt]; cnt increments.
  - After cnt==WIDTH-1 -> CHECK.
  - sr_shift_en and sr_din are decoded from flops only, with no input paths.
- CHECK, cycle T+WIDTH+1:
  - sr_shift_en=0; sample sr_pout.
  - Registered outputs appear at T+WIDTH+2: done=1 for exactly one cycle, done_data=sr_pout, done_id=owner, done_err=(sr_pout!=hold).
  - done_data, done_id and done_err hold their values until the next done.
  - Next state GAP if GAP_CYC>0, else IDLE.
- GAP: counts GAP_CYC cycles, then IDLE. New requests are ignored and ready stays low.
- Throughput: next accept is earliest at T+WIDTH+2+GAP_CYC, i.e. one frame per WIDTH+2+GAP_CYC cycles.
- Requesters may change or drop valid/data after the transfer cycle without effect; hold is the only source.
- A valid deasserted before ready is a legal withdrawal and no grant is recorded.
- Reset asserted in any state returns to IDLE immediately. Deassertion takes effect on the next rising edge.
- cnt width is clog2(WIDTH). The WIDTH-1 terminal compare must not wrap for WIDTH a power of two.

Decomposition:
- Package sreg_sched_pkg holds:
  - state enum (IDLE, SHIFT, CHECK, GAP);
  - WIDTH default constant;
  - requester-id typedef.
- One sub-module, rr_arb2: 2-way round-robin grant with last_gnt flop. Update is enabled only on a completed transfer; it uses the same async active-low res.

Test Plan:
- res low mid-SHIFT after 3 shifts -> all outputs 0 at once; no done; after release, next tie grants req0.
- req0_valid with data 0xA5, req1 idle, chain model attached:
  - sr_din = 1,0,1,0,0,1,0,1 over T+1..T+8;
  - done at T+10 with done_data=0xA5, done_id=0, done_err=0.
- Both valid continuously, req0=0x3C, req1=0xC3:
  - grants alternate 0,1,0,1;
  - accepts spaced exactly WIDTH+2+GAP_CYC=11 cycles apart.
- Chain model forces sr_pout bit 0 stuck-at-1, send 0x00 -> done_data=0x01, done_err=1.
- GAP_CYC=0 with req1 always valid -> back-to-back frames, req1_ready every 10 cycles, busy low for exactly 1 cycle between frames.
- req0_valid held high during SHIFT/CHECK/GAP and data changed to 0xFF after accept -> req0_ready stays 0 until the next IDLE; the in-flight frame still reports its original byte.
